// File: rtl/mem_arbiter.sv
// Two-port core-memory arbiter: grants the data-break or CPU requester one
// read/restore memory cycle (read, write or increment) and runs the handshake.
module mem_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [1:0]  cpu_op,
    input  logic [14:0] cpu_addr,
    input  logic [11:0] cpu_wdata,
    output logic        cpu_ack,
    input  logic        brk_req,
    input  logic [1:0]  brk_op,
    input  logic [14:0] brk_addr,
    input  logic [11:0] brk_wdata,
    output logic        brk_ack,
    output logic [11:0] rdata,
    output logic        busy,
    output logic        timeout_err,
    output logic        mem_start,
    input  logic        mem_done_n,
    input  logic        strobe_n,
    output logic [14:0] mem_addr,
    output logic [11:0] mem_wdata,
    input  logic [11:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        SENSE   = 3'd2,
        RESTORE = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;

    state_t      state, state_nxt;
    logic        sel_brk;
    logic [1:0]  op_q;
    logic        aborted;
    logic [7:0]  tmo_cnt;
    logic        grant;
    logic        capture;

    function automatic logic [11:0] inc_wrap(input logic [11:0] v);
        return v + 12'd1;
    endfunction

    function automatic logic [1:0] norm_op(input logic [1:0] op);
        return (op == 2'b11) ? OP_READ : op;
    endfunction

    assign grant   = (state == IDLE) && (brk_req || cpu_req);
    assign capture = (state == SENSE) && !strobe_n && !timeout_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        mem_start   = 1'b0;
        busy        = 1'b1;
        cpu_ack     = 1'b0;
        brk_ack     = 1'b0;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (brk_req || cpu_req) state_nxt = ARM;
            end
            ARM, SENSE, RESTORE: begin
                mem_start = 1'b1;
                // Abort wins over any handshake progress in the same cycle.
                if (tmo_cnt == TIMEOUT) begin
                    timeout_err = 1'b1;
                    state_nxt   = RELEASE;
                end else if (state == ARM && mem_done_n) begin
                    state_nxt = SENSE;
                end else if (state == SENSE && !strobe_n) begin
                    state_nxt = RESTORE;
                end else if (state == RESTORE && !mem_done_n) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                cpu_ack   = !aborted && !sel_brk;
                brk_ack   = !aborted && sel_brk;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_brk   <= 1'b0;
            op_q      <= OP_READ;
            aborted   <= 1'b0;
            tmo_cnt   <= 8'd0;
            mem_addr  <= 15'd0;
            mem_wdata <= 12'd0;
            rdata     <= 12'd0;
        end else begin
            if (grant) begin
                sel_brk   <= brk_req;
                op_q      <= norm_op(brk_req ? brk_op : cpu_op);
                mem_addr  <= brk_req ? brk_addr : cpu_addr;
                mem_wdata <= brk_req ? brk_wdata : cpu_wdata;
                aborted   <= 1'b0;
                tmo_cnt   <= 8'd0;
            end else if (mem_start) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            if (timeout_err) aborted <= 1'b1;
            // Reads restore the sensed word; increments restore it plus one.
            if (capture) begin
                rdata <= mem_rdata;
                if (op_q == OP_READ)     mem_wdata <= mem_rdata;
                else if (op_q == OP_INC) mem_wdata <= inc_wrap(mem_rdata);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: emulated 150-cycle core memory plus a
// transaction-level reference model of memory contents and read data.
module tb_mem_arbiter;

    localparam int MEM_CYC = 150;
    localparam int TMO     = 200;
    localparam int BOUND   = 400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic [1:0]  cpu_op = 2'b00;
    logic [14:0] cpu_addr = 15'd0;
    logic [11:0] cpu_wdata = 12'd0;
    logic        cpu_ack;
    logic        brk_req = 1'b0;
    logic [1:0]  brk_op = 2'b00;
    logic [14:0] brk_addr = 15'd0;
    logic [11:0] brk_wdata = 12'd0;
    logic        brk_ack;
    logic [11:0] rdata;
    logic        busy, timeout_err, mem_start;
    logic        mem_done_n = 1'b0;
    logic        strobe_n = 1'b1;
    logic [11:0] mem_rdata = 12'd0;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;

    logic [11:0] phys_mem [32768];
    int          ref_mem [32768];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cpu_acks = 0, brk_acks = 0, tmo_pulses = 0, start_rises = 0;
    logic        mon_prev = 1'b0;
    bit          loaded = 0, dev_act = 0, dev_hang = 0, prev_start = 0;
    int          dev_t = 0;
    logic [14:0] dev_a = 15'd0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(8'd200)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .brk_req(brk_req), .brk_op(brk_op), .brk_addr(brk_addr), .brk_wdata(brk_wdata), .brk_ack(brk_ack),
        .rdata(rdata), .busy(busy), .timeout_err(timeout_err), .mem_start(mem_start),
        .mem_done_n(mem_done_n), .strobe_n(strobe_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic int init_val(input int i);
        if (i == 'o100) return 'o1234;
        if (i == 'o10)  return 'o7777;
        return (i * 37 + 5) % 4096;
    endfunction

    function automatic int ref_next(input logic [1:0] op, input int old, input int wd);
        if (op == 2'b01) return wd;
        if (op == 2'b10) return (old + 1) % 4096;
        return old;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Core memory: start seen -> busy at +2, strobe at +60..+69, restore/done at +150.
    always @(negedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 32768; i++) phys_mem[i] = 12'(init_val(i));
            loaded = 1;
        end
        if (dev_act && !mem_start) dev_act = 0;
        if (dev_act) begin
            dev_t++;
            if (dev_t == 2) mem_done_n = 1'b1;
            if (!dev_hang && dev_t == 60) begin
                strobe_n  = 1'b0;
                mem_rdata = phys_mem[dev_a];
            end
            if (dev_t == 70) strobe_n = 1'b1;
            if (!dev_hang && dev_t == MEM_CYC) begin
                phys_mem[dev_a] = mem_wdata;
                mem_done_n = 1'b0;
                dev_act = 0;
            end
        end else begin
            strobe_n   = 1'b1;
            mem_done_n = dev_hang;
            if (mem_start && !prev_start) begin
                dev_act = 1;
                dev_t   = 0;
                dev_a   = mem_addr;
            end
        end
        prev_start = mem_start;
    end

    always @(negedge clk) begin
        if (cpu_ack) cpu_acks <= cpu_acks + 1;
        if (brk_ack) brk_acks <= brk_acks + 1;
        if (timeout_err) tmo_pulses <= tmo_pulses + 1;
        if (mem_start && !mon_prev) start_rises <= start_rises + 1;
        mon_prev <= mem_start;
    end

    task automatic set_req(input bit b, input bit v, input logic [1:0] op,
                           input logic [14:0] a, input logic [11:0] wd);
        if (b) begin brk_req = v; brk_op = op; brk_addr = a; brk_wdata = wd; end
        else   begin cpu_req = v; cpu_op = op; cpu_addr = a; cpu_wdata = wd; end
    endtask

    task automatic wait_ack(input bit b, output int cyc, output bit got);
        cyc = 0;
        got = 0;
        while (!got && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            got = b ? brk_ack : cpu_ack;
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, " busy"}, 32'(busy), 32'd0);
        check({pfx, " mem_start"}, 32'(mem_start), 32'd0);
        check({pfx, " cpu_ack"}, 32'(cpu_ack), 32'd0);
        check({pfx, " brk_ack"}, 32'(brk_ack), 32'd0);
        check({pfx, " timeout_err"}, 32'(timeout_err), 32'd0);
        check({pfx, " rdata"}, 32'(rdata), 32'd0);
        check({pfx, " mem_addr"}, 32'(mem_addr), 32'd0);
        check({pfx, " mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    task automatic do_xact(input string tag, input bit b, input logic [1:0] op,
                           input logic [14:0] a, input logic [11:0] wd);
        int old, nxt, cyc, own0, other0;
        bit got;
        old    = ref_mem[a];
        nxt    = ref_next(op, old, int'(wd));
        own0   = b ? brk_acks : cpu_acks;
        other0 = b ? cpu_acks : brk_acks;
        @(negedge clk);
        set_req(b, 1'b1, op, a, wd);
        wait_ack(b, cyc, got);
        set_req(b, 1'b0, op, a, wd);
        check({tag, " ack"}, 32'(got), 32'd1);
        check({tag, " latency"}, cyc, MEM_CYC + 2);
        check({tag, " rdata"}, 32'(rdata), old);
        check({tag, " memory"}, 32'(phys_mem[a]), nxt);
        @(negedge clk);
        check({tag, " own acks"}, b ? brk_acks : cpu_acks, own0 + 1);
        check({tag, " other acks"}, b ? cpu_acks : brk_acks, other0);
        ref_mem[a] = nxt;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete, %0d checks made", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int old_b, old_c, cyc_b, cyc_c, cpu0, r0, t0, a0, arm_c, tmo_c, cyc;
        bit got_b, got_c;
        logic [11:0] rd0;
        logic [14:0] ra;
        logic [1:0]  rop;
        logic [11:0] rwd;
        bit          rb;

        for (int i = 0; i < 32768; i++) ref_mem[i] = init_val(i);
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        do_xact("cpu read 00100", 1'b0, 2'b00, 15'o00100, 12'o0000);
        check("read rdata 1234", 32'(rdata), 32'o1234);
        do_xact("cpu write 77777", 1'b0, 2'b01, 15'o77777, 12'o5555);
        do_xact("cpu read 77777", 1'b0, 2'b00, 15'o77777, 12'o0000);
        check("readback 5555", 32'(rdata), 32'o5555);
        check("no brk ack yet", brk_acks, 0);
        do_xact("brk inc 00010", 1'b1, 2'b10, 15'o00010, 12'o0000);
        check("inc rdata 7777", 32'(rdata), 32'o7777);
        check("inc wraps to 0", 32'(phys_mem[15'o00010]), 32'd0);

        // Simultaneous requests: break port first, CPU in the next cycle.
        old_b = ref_mem['o200];
        old_c = ref_mem['o300];
        cpu0  = cpu_acks;
        r0    = start_rises;
        @(negedge clk);
        set_req(1'b1, 1'b1, 2'b10, 15'o00200, 12'o0000);
        set_req(1'b0, 1'b1, 2'b01, 15'o00300, 12'o4321);
        wait_ack(1'b1, cyc_b, got_b);
        set_req(1'b1, 1'b0, 2'b10, 15'o00200, 12'o0000);
        check("both brk ack", 32'(got_b), 32'd1);
        check("both brk rdata", 32'(rdata), old_b);
        check("both cpu waits", cpu_acks, cpu0);
        wait_ack(1'b0, cyc_c, got_c);
        set_req(1'b0, 1'b0, 2'b01, 15'o00300, 12'o4321);
        check("both cpu ack", 32'(got_c), 32'd1);
        check("both cpu spacing", cyc_c, MEM_CYC + 3);
        check("both cpu rdata", 32'(rdata), old_c);
        check("both brk memory", 32'(phys_mem[15'o00200]), (old_b + 1) % 4096);
        check("both cpu memory", 32'(phys_mem[15'o00300]), 32'o4321);
        ref_mem['o200] = (old_b + 1) % 4096;
        ref_mem['o300] = 'o4321;
        @(negedge clk);
        check("both start rises", start_rises - r0, 2);

        // Dead memory: mem_done_n stuck high, no strobe.
        dev_hang = 1;
        rd0 = rdata;
        t0  = tmo_pulses;
        a0  = cpu_acks + brk_acks;
        @(negedge clk);
        set_req(1'b0, 1'b1, 2'b00, 15'o00400, 12'o0000);
        arm_c = -1;
        tmo_c = -1;
        cyc   = 0;
        while (tmo_c < 0 && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            if (mem_start && arm_c < 0) arm_c = cyc;
            if (timeout_err) tmo_c = cyc;
        end
        set_req(1'b0, 1'b0, 2'b00, 15'o00400, 12'o0000);
        check("timeout distance", tmo_c - arm_c, TMO);
        repeat (3) @(negedge clk);
        check("timeout pulses", tmo_pulses - t0, 1);
        check("timeout no ack", cpu_acks + brk_acks, a0);
        check("timeout idle", 32'(busy), 32'd0);
        check("timeout rdata kept", 32'(rdata), 32'(rd0));
        check("timeout memory", 32'(phys_mem[15'o00400]), ref_mem['o400]);
        dev_hang = 0;
        repeat (2) @(negedge clk);

        // Asynchronous reset while sensing.
        @(negedge clk);
        set_req(1'b0, 1'b1, 2'b10, 15'o00500, 12'o1111);
        cyc = 0;
        while (!(dev_act && dev_t >= 30) && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        check("sense reached", 32'(cyc < BOUND), 32'd1);
        set_req(1'b0, 1'b0, 2'b10, 15'o00500, 12'o1111);
        a0 = cpu_acks + brk_acks;
        #2 reset = 1'b1;
        #1 check_zero("async reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("reset no ack", cpu_acks + brk_acks, a0);
        check("reset memory", 32'(phys_mem[15'o00500]), ref_mem['o500]);
        do_xact("after reset inc", 1'b0, 2'b10, 15'o00500, 12'o1111);

        for (int k = 0; k < 8; k++) begin
            rb  = 1'($urandom_range(0, 1));
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       ra = 15'o00100;
                1:       ra = 15'o77777;
                2:       ra = 15'o00010;
                default: ra = 15'($urandom);
            endcase
            rwd = 12'($urandom);
            do_xact("random", rb, rop, ra, rwd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 8'd200, max cycles from mem_start assertion to mem_done_n low before abort.
REQ-002 clk  input  1  system clock, 100 MHz; all state on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU cycle request, level, held until cpu_ack.
REQ-005 cpu_op  input  2  00 read, 01 write, 10 increment, 11 treated as read.
REQ-006 cpu_addr  input  15  CPU word address.
REQ-007 cpu_wdata  input  12  CPU write data.
REQ-008 cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-009 brk_req, brk_op, brk_addr, brk_wdata, brk_ack: data-break port, same widths and meaning as CPU port.
REQ-010 rdata  output  12  word read from memory during the completed cycle, valid from ack onward until next capture.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 timeout_err  output  1  one-cycle pulse on abort.
REQ-013 mem_start  output  1  to memory; rising edge starts a core cycle.
REQ-014 mem_done_n  input  1  from memory; low = cycle complete.
REQ-015 strobe_n  input  1  from memory; low = read data valid.
REQ-016 mem_addr  output  15  address to memory.
REQ-017 mem_wdata  output  12  data to memory (write-back/restore).
REQ-018 mem_rdata  input  12  data from memory.

Function
REQ-019 States: IDLE, ARM, SENSE, RESTORE, RELEASE; state register 3 bits.
REQ-020 IDLE: brk_req has fixed priority over cpu_req; grant only in IDLE; on grant latch requester id, op, addr, wdata; next ARM.
REQ-021 Requests arriving, changing or dropping outside IDLE are ignored until the next IDLE.
REQ-022 ARM: mem_start=1; wait for mem_done_n=1 (memory acknowledged start); next SENSE.
REQ-023 SENSE: on first cycle strobe_n=0, capture mem_rdata into rdata; next RESTORE.
REQ-024 RESTORE: wait for mem_done_n=0; next RELEASE.
REQ-025 RELEASE: mem_start=0 for exactly one cycle; pulse ack of latched requester; next IDLE.
REQ-026 mem_start=1 exactly in ARM, SENSE, RESTORE; it is therefore low at least one cycle between consecutive cycles.
REQ-027 mem_addr = latched address, stable from ARM through RELEASE.
REQ-028 mem_wdata: write op -> latched wdata from ARM; read op -> rdata once captured (restore); increment -> (rdata+1) mod 4096 once captured.
REQ-029 Increment: 12'o7777 writes back 12'o0000; rdata returns pre-increment value.
REQ-030 Latency grant-to-ack: memory cycle length + 2 cycles; ack never in same cycle as grant.
REQ-031 Timeout counter cleared on entering ARM, increments each cycle in ARM/SENSE/RESTORE; at TIMEOUT: pulse timeout_err, go RELEASE without ack, rdata unchanged.
REQ-032 Both requests asserted in IDLE same cycle: brk granted; cpu granted in the IDLE following brk_ack if still asserted.
REQ-033 brk held continuously starves cpu; accepted.

Reset
REQ-034 Reset asserted at any time: state IDLE immediately; mem_start, cpu_ack, brk_ack, timeout_err, busy = 0; rdata, mem_addr, mem_wdata = 0; timeout counter 0.
REQ-035 Reset mid-cycle produces no ack; first grant after reset release occurs no earlier than the first clock edge with reset low.

Verification
REQ-036 Memory model with 150-cycle core timing; cpu read of 15'o00100 preloaded 12'o1234 -> one cpu_ack, rdata=12'o1234, memory still 12'o1234.
REQ-037 cpu write 12'o5555 to 15'o77777 then read -> rdata=12'o5555; no brk_ack seen.
REQ-038 brk increment at 15'o00010 holding 12'o7777 -> brk_ack, rdata=12'o7777, memory now 12'o0000.
REQ-039 cpu_req and brk_req asserted same cycle -> brk_ack first, cpu_ack one full memory cycle later; mem_start low ≥1 cycle between.
REQ-040 mem_done_n tied high -> timeout_err pulse TIMEOUT cycles after ARM entry, no ack, returns IDLE.
REQ-041 Reset pulsed during SENSE -> all outputs zero asynchronously, no ack; next request completes normally.
